itlb_ctrl: RTL
==============

// Module: itlb_ctrl
// PURPOSE
//  Lookup/refill controller sitting directly upstream of the ITLB entry array.
//  - Holds the per-entry VPN tags and valid bits.
//  - Resolves hit/miss for fetch translation requests.
//  - Issues page-table-walk (PTW) requests on a miss and writes the returned PTE into a chosen victim.
//  - Drives the entry array's one-hot read enable, one-hot write enable and PTE write data.
// PARAMETERS
//  ENTRY_NUM  8   number of ITLB entries; must equal `ITLB_ENTRY_NUM
//  VPN_W      27  virtual page number width (Sv39)
//  PTE_W      64  PTE width; must equal `MXLEN
// PORTS
//  clk_i             in   1          clock, rising edge
//  rstn_i            in   1          asynchronous active-low reset
//  lookup_valid_i    in   1          translation request valid
//  lookup_vpn_i      in   VPN_W      VPN to translate
//  lookup_ready_o    out  1          request accepted when valid & ready
//  resp_valid_o      out  1          response strobe, one cycle
//  resp_hit_o        out  1          1 = hit in TLB; 0 = miss, refilled
//  resp_fault_o      out  1          PTW reported an error; no entry written
//  ptw_req_valid_o   out  1          PTW request
//  ptw_req_ready_i   in   1          PTW accepts request
//  ptw_req_vpn_o     out  VPN_W      VPN sent to PTW
//  ptw_resp_valid_i  in   1          PTW response strobe
//  ptw_resp_pte_i    in   PTE_W      leaf PTE
//  ptw_resp_err_i    in   1          page fault / access fault from walk
//  flush_i           in   1          sfence.vma: invalidate all entries
//  entry_rd_en_o     out  ENTRY_NUM  one-hot read select to entry array
//  entry_wr_en_o     out  ENTRY_NUM  one-hot write select to entry array
//  entry_pte_wr_o    out  PTE_W      PTE write data to entry array
// BEHAVIOUR
//  Reset values
//  - All outputs 0; all valid bits 0; victim pointer 0; state IDLE; kill flag 0.
//  FSM states: IDLE, CMP, PTW_REQ, PTW_WAIT, REFILL, RESP
//  - IDLE: lookup_ready_o = !flush_i. On accept, register the VPN and go to CMP.
//  - CMP: compare the registered VPN against all valid tags.
//    - Hit: entry_rd_en_o one-hot at the matching index (lowest index if several),
//      resp_valid_o=1, resp_hit_o=1, then IDLE. Latency from accept to hit response is 1 cycle.
//    - Miss: go to PTW_REQ.
//  - PTW_REQ: ptw_req_valid_o=1 with ptw_req_vpn_o stable until ptw_req_ready_i, then PTW_WAIT.
//    Valid never drops before the handshake.
//  - PTW_WAIT: on ptw_resp_valid_i:
//    - kill set: clear kill, go to IDLE; no write, no response.
//    - ptw_resp_err_i=1: resp_valid_o=1, resp_fault_o=1, go to IDLE; no write.
//    - Otherwise: go to REFILL.
//  - REFILL: entry_wr_en_o one-hot at victim, entry_pte_wr_o = captured PTE; tag <= VPN; valid <= 1.
//    Then RESP.
//  - RESP: entry_rd_en_o one-hot at victim, resp_valid_o=1, resp_hit_o=0, then IDLE.
//  Victim selection
//  - Lowest-index invalid entry if any exists.
//  - Otherwise the round-robin pointer. The pointer advances only when it was used,
//    wrapping ENTRY_NUM-1 -> 0.
//  Flush
//  - flush_i clears all valid bits in the same cycle; the pointer is unchanged.
//  - IDLE: takes priority over a same-cycle lookup; the lookup is not accepted.
//  - CMP, REFILL or RESP: abort to IDLE with no response and no write.
//  - PTW_REQ or PTW_WAIT: set kill; the handshake and response complete, then are discarded.
//  - Same cycle as ptw_resp_valid_i: the response is discarded.
//  Output rules
//  - entry_rd_en_o and entry_wr_en_o are never both nonzero in one cycle.
//  - Each is zero or one-hot at all times.
//  - resp_* outputs are zero outside the response cycle.
// CONFIGURATION
//  ITLB_PERF_CNT_EN defined:
//  - Adds outputs perf_hit_cnt_o[31:0] and perf_miss_cnt_o[31:0].
//  - Hit counter +1 per CMP hit; miss counter +1 per CMP miss.
//  - Both saturate at 32'hFFFF_FFFF, reset to 0, and are not cleared by flush_i.
//  ITLB_PERF_CNT_EN undefined:
//  - No counters and no extra ports; behaviour is otherwise identical.
// TESTING
//  1. Reset, lookup VPN 0x123 -> PTW req VPN 0x123; resp PTE 0xCF -> wr_en 8'h01,
//     then rd_en 8'h01, resp_hit=0.
//  2. Repeat VPN 0x123 -> exactly 1 cycle later rd_en 8'h01, resp_hit=1; no PTW request.
//  3. Fill 8 distinct VPNs, then a 9th -> victim entry 0; a 10th -> victim entry 1.
//  4. Miss on VPN 0x55, ptw_resp_err=1 -> resp_fault=1, wr_en stays 0;
//     lookup 0x55 again -> new PTW request.
//  5. flush_i asserted during PTW_WAIT -> PTW response dropped, no resp_valid;
//     all later lookups miss.
//  6. flush_i and lookup_valid_i in the same IDLE cycle -> lookup_ready=0, request held;
//     accepted next cycle.

Source files
------------

// File: rtl/itlb_ctrl.sv
// itlb_ctrl: lookup/refill controller for the ITLB entry array.
// Keeps the VPN tags and valid bits, resolves hits, runs page-table walks on
// misses and writes the returned PTE into a victim entry.
// Optional build macro: ITLB_PERF_CNT_EN adds saturating hit/miss counters.
//
// state    | meaning
// IDLE     | ready for a new lookup
// CMP      | compare registered VPN against valid tags
// PTW_REQ  | presenting walk request, waiting for ready
// PTW_WAIT | walk in flight, waiting for response
// REFILL   | writing captured PTE into the victim entry
// RESP     | miss response, reading back the refilled entry
module itlb_ctrl #(
  parameter int ENTRY_NUM = 8,
  parameter int VPN_W     = 27,
  parameter int PTE_W     = 64
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 lookup_valid_i,
  input  logic [VPN_W-1:0]     lookup_vpn_i,
  output logic                 lookup_ready_o,
  output logic                 resp_valid_o,
  output logic                 resp_hit_o,
  output logic                 resp_fault_o,
  output logic                 ptw_req_valid_o,
  input  logic                 ptw_req_ready_i,
  output logic [VPN_W-1:0]     ptw_req_vpn_o,
  input  logic                 ptw_resp_valid_i,
  input  logic [PTE_W-1:0]     ptw_resp_pte_i,
  input  logic                 ptw_resp_err_i,
  input  logic                 flush_i,
`ifdef ITLB_PERF_CNT_EN
  output logic [31:0]          perf_hit_cnt_o,
  output logic [31:0]          perf_miss_cnt_o,
`endif
  output logic [ENTRY_NUM-1:0] entry_rd_en_o,
  output logic [ENTRY_NUM-1:0] entry_wr_en_o,
  output logic [PTE_W-1:0]     entry_pte_wr_o
);

  localparam int IDX_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
  localparam logic [ENTRY_NUM-1:0] ONE = ENTRY_NUM'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRY_NUM - 1);

  typedef enum logic [2:0] {
    IDLE, CMP, PTW_REQ, PTW_WAIT, REFILL, RESP
  } state_t;

  state_t             state_q, state_d;
  logic               kill_q, kill_d;
  logic [VPN_W-1:0]   vpn_q;
  logic [PTE_W-1:0]   pte_q;
  logic [VPN_W-1:0]   tag_q [ENTRY_NUM];
  logic [ENTRY_NUM-1:0] valid_q;
  logic [IDX_W-1:0]   rr_q;
  logic [IDX_W-1:0]   victim_q;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               has_inv;
  logic [IDX_W-1:0]   inv_idx;
  logic [IDX_W-1:0]   victim_idx;
  logic               latch_req;
  logic               latch_pte;
  logic               do_refill;

  // Tag match; descending scan leaves the lowest matching index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == vpn_q)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Victim choice: lowest invalid entry, else the round-robin pointer.
  always_comb begin
    has_inv = 1'b0;
    inv_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        has_inv = 1'b1;
        inv_idx = IDX_W'(i);
      end
    end
    victim_idx = has_inv ? inv_idx : rr_q;
  end

  // Next-state and output decode.
  always_comb begin
    state_d         = state_q;
    kill_d          = kill_q;
    lookup_ready_o  = 1'b0;
    resp_valid_o    = 1'b0;
    resp_hit_o      = 1'b0;
    resp_fault_o    = 1'b0;
    ptw_req_valid_o = 1'b0;
    entry_rd_en_o   = '0;
    entry_wr_en_o   = '0;
    latch_req       = 1'b0;
    latch_pte       = 1'b0;
    do_refill       = 1'b0;
    case (state_q)
      IDLE: begin
        lookup_ready_o = !flush_i;
        if (lookup_valid_i && !flush_i) begin
          latch_req = 1'b1;
          state_d   = CMP;
        end
      end
      CMP: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (hit) begin
          entry_rd_en_o = ONE << hit_idx;
          resp_valid_o  = 1'b1;
          resp_hit_o    = 1'b1;
          state_d       = IDLE;
        end else begin
          state_d = PTW_REQ;
        end
      end
      PTW_REQ: begin
        ptw_req_valid_o = 1'b1;
        if (flush_i) kill_d = 1'b1;
        if (ptw_req_ready_i) state_d = PTW_WAIT;
      end
      PTW_WAIT: begin
        if (ptw_resp_valid_i) begin
          if (kill_q || flush_i) begin
            kill_d  = 1'b0;
            state_d = IDLE;
          end else if (ptw_resp_err_i) begin
            resp_valid_o = 1'b1;
            resp_fault_o = 1'b1;
            state_d      = IDLE;
          end else begin
            latch_pte = 1'b1;
            state_d   = REFILL;
          end
        end else if (flush_i) begin
          kill_d = 1'b1;
        end
      end
      REFILL: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          entry_wr_en_o = ONE << victim_idx;
          do_refill     = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (!flush_i) begin
          entry_rd_en_o = ONE << victim_q;
          resp_valid_o  = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ptw_req_vpn_o  = ptw_req_valid_o ? vpn_q : '0;
  assign entry_pte_wr_o = do_refill ? pte_q : '0;

  // Control state, request/PTE capture and victim bookkeeping.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      kill_q   <= 1'b0;
      vpn_q    <= '0;
      pte_q    <= '0;
      rr_q     <= '0;
      victim_q <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (latch_req) vpn_q <= lookup_vpn_i;
      if (latch_pte) pte_q <= ptw_resp_pte_i;
      if (do_refill) begin
        victim_q <= victim_idx;
        if (!has_inv) rr_q <= (rr_q == LAST_IDX) ? '0 : rr_q + IDX_W'(1);
      end
    end
  end

  // Tag and valid storage; flush clears valids but leaves the pointer alone.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) tag_q[i] <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (do_refill) begin
      valid_q[victim_idx] <= 1'b1;
      tag_q[victim_idx]   <= vpn_q;
    end
  end

`ifdef ITLB_PERF_CNT_EN
  logic hit_evt;
  logic miss_evt;
  assign hit_evt  = (state_q == CMP) && !flush_i && hit;
  assign miss_evt = (state_q == CMP) && !flush_i && !hit;

  // Saturating performance counters, untouched by flush.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      perf_hit_cnt_o  <= '0;
      perf_miss_cnt_o <= '0;
    end else begin
      if (hit_evt && (perf_hit_cnt_o != 32'hFFFF_FFFF))
        perf_hit_cnt_o <= perf_hit_cnt_o + 32'd1;
      if (miss_evt && (perf_miss_cnt_o != 32'hFFFF_FFFF))
        perf_miss_cnt_o <= perf_miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule
